// File: rtl/eight_bit_accumulator_if.sv
// eight_bit_accumulator_if: bundles the request, operand stream and result
// signals of the eight-bit accumulator.
//   master : the requester. It drives Start/Len, the operand stream
//            (In_Valid/In_Data) and the result Out_Ready.
//   slave  : the accumulator. It drives In_Ready, Out_Valid, Sum, Cout,
//            Count and Busy.
interface eight_bit_accumulator_if #(
  parameter int COUNT_W = 4
);
  logic               Start;
  logic [COUNT_W-1:0] Len;
  logic               In_Valid;
  logic               In_Ready;
  logic [7:0]         In_Data;
  logic               Out_Valid;
  logic               Out_Ready;
  logic [7:0]         Sum;
  logic               Cout;
  logic [COUNT_W-1:0] Count;
  logic               Busy;

  modport master (
    output Start, Len, In_Valid, In_Data, Out_Ready,
    input  In_Ready, Out_Valid, Sum, Cout, Count, Busy
  );

  modport slave (
    input  Start, Len, In_Valid, In_Data, Out_Ready,
    output In_Ready, Out_Valid, Sum, Cout, Count, Busy
  );
endinterface

// File: rtl/eight_bit_accumulator.sv
// eight_bit_accumulator: sums a run of Len unsigned 8-bit operands.
//   Clk  : rising-edge clock
//   Rst  : synchronous active-high reset. It wins over every other input.
//   bus  : eight_bit_accumulator_if.slave
//          Start/Len          start a run. Sampled only in IDLE.
//          In_Valid/In_Ready  operand handshake. In_Ready is high only in ACCUM.
//          In_Data            operand
//          Out_Valid/Out_Ready result handshake. Out_Valid is high only in DONE.
//          Sum/Cout/Count     result, sticky carry and number of operands taken
//          Busy               high in ACCUM and DONE
// Parameters:
//   COUNT_W  : width of Len and Count
//   SATURATE : 0 wraps Sum modulo 256. 1 clamps Sum to 8'hFF once any carry
//              has been seen.
module eight_bit_accumulator #(
  parameter int COUNT_W  = 4,
  parameter int SATURATE = 0
) (
  input logic                          Clk,
  input logic                          Rst,
  eight_bit_accumulator_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state;
  logic [COUNT_W-1:0] len_q;
  logic [7:0]         sum_q;
  logic               cout_q;
  logic [COUNT_W-1:0] count_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  // 9-bit add so that bit 8 is the carry-out of this operand's addition.
  logic [8:0] add_full;
  logic       xfer;
  logic       last_op;
  logic       sat_hit;

  assign add_full = {1'b0, sum_q} + {1'b0, bus.In_Data};
  assign xfer     = bus.In_Valid & in_ready_q;
  // Len is never zero in ACCUM, so len_q - 1 cannot underflow here.
  assign last_op  = (count_q == len_q - COUNT_W'(1));
  // Once any carry has been seen the clamp sticks for the rest of the run.
  assign sat_hit  = (SATURATE != 0) && (add_full[8] || cout_q);

  // The handshake outputs are registered alongside the state. They always
  // equal the decode of the state register, without a combinational path
  // from the inputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The previous result stays visible until a new run starts.
          if (bus.Start) begin
            len_q   <= bus.Len;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b1;
            if (bus.Len != '0) begin
              state      <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              // A run of zero operands produces an empty result at once.
              state       <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (xfer) begin
            sum_q   <= sat_hit ? 8'hFF : add_full[7:0];
            cout_q  <= cout_q | add_full[8];
            count_q <= count_q + COUNT_W'(1);
            if (last_op) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          // Start is ignored here, including in the handshake cycle.
          if (bus.Out_Ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.In_Ready  = in_ready_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Count     = count_q;
  assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_eight_bit_accumulator.sv
// tb_eight_bit_accumulator: drives the same stimulus into two accumulators.
// One wraps (SATURATE=0) and one clamps (SATURATE=1). Every cycle, both are
// checked against a reference built from the queue of operands taken in the
// current run.
module tb_eight_bit_accumulator;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          out_ready = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  eight_bit_accumulator_if #(.COUNT_W(CW)) bw ();
  eight_bit_accumulator_if #(.COUNT_W(CW)) bs ();

  assign bw.Start = start;   assign bs.Start = start;
  assign bw.Len = len;       assign bs.Len = len;
  assign bw.In_Valid = in_valid;   assign bs.In_Valid = in_valid;
  assign bw.In_Data = in_data;     assign bs.In_Data = in_data;
  assign bw.Out_Ready = out_ready; assign bs.Out_Ready = out_ready;

  eight_bit_accumulator #(.COUNT_W(CW), .SATURATE(0)) dut_wrap (
    .Clk(clk), .Rst(rst), .bus(bw.slave));
  eight_bit_accumulator #(.COUNT_W(CW), .SATURATE(1)) dut_sat (
    .Clk(clk), .Rst(rst), .bus(bs.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 waiting for a start, 1 taking operands, 2 holding a result
  int         m_phase = 0;
  int         m_len = 0;
  logic [7:0] m_ops[$];

  // Sum and sticky carry follow directly from the operand list.
  function automatic void model_result(input bit sat, output logic [7:0] s, output logic c);
    int t;
    s = 8'h00;
    c = 1'b0;
    foreach (m_ops[i]) begin
      t = int'(s) + int'(m_ops[i]);
      if (t > 255) c = 1'b1;
      s = t[7:0];
      if (sat && c) s = 8'hFF;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_ops.delete();
    end else if (m_phase == 0) begin
      if (start) begin
        m_ops.delete();
        m_len   = int'(len);
        m_phase = (len == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_ops.push_back(in_data);
        if (m_ops.size() == m_len) m_phase = 2;
      end
    end else begin
      if (out_ready) m_phase = 0;
    end
  end

  // Compare both DUTs against the model on every falling edge.
  always @(negedge clk) begin
    logic [7:0] es_w, es_s;
    logic       ec_w, ec_s;
    model_result(1'b0, es_w, ec_w);
    model_result(1'b1, es_s, ec_s);
    chk("in_ready",   32'(bw.In_Ready),  32'(m_phase == 1));
    chk("out_valid",  32'(bw.Out_Valid), 32'(m_phase == 2));
    chk("busy",       32'(bw.Busy),      32'(m_phase != 0));
    chk("sum_wrap",   32'(bw.Sum),       32'(es_w));
    chk("cout_wrap",  32'(bw.Cout),      32'(ec_w));
    chk("count",      32'(bw.Count),     32'(m_ops.size()));
    chk("sum_sat",    32'(bs.Sum),       32'(es_s));
    chk("cout_sat",   32'(bs.Cout),      32'(ec_s));
    chk("sat_state",  32'({bs.In_Ready, bs.Out_Valid, bs.Busy, bs.Count}),
                      32'({m_phase == 1, m_phase == 2, m_phase != 0, 4'(m_ops.size())}));
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [CW-1:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (!bw.In_Ready && n < 40) begin tick(); n++; end
    if (n >= 40) chk("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_run();
    int n = 0;
    while (!bw.Out_Valid && n < 40) begin tick(); n++; end
    if (n >= 40) chk("done_timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_outs", 32'({bw.Sum, bw.Cout, bw.Count, bw.In_Ready, bw.Out_Valid, bw.Busy}), 32'd0);
    // The first start is honoured on the first edge after reset is released.
    rst = 1'b0;
    start_run(4'd3);
    chk("first_start_busy", 32'(bw.Busy), 32'd1);

    // Three back-to-back operands. The result is visible one cycle after the last.
    send_op(8'h10); send_op(8'h20); send_op(8'h30);
    chk("r32_valid", 32'(bw.Out_Valid), 32'd1);
    chk("r32_sum",   32'(bw.Sum),       32'h60);
    chk("r32_cout",  32'(bw.Cout),      32'd0);
    chk("r32_count", 32'(bw.Count),     32'd3);
    finish_run();

    // Carry: one DUT wraps, the other clamps.
    start_run(4'd2);
    send_op(8'hF0); send_op(8'h20);
    chk("r33_sum_wrap", 32'(bw.Sum),  32'h10);
    chk("r33_cout",     32'(bw.Cout), 32'd1);
    chk("r33_sum_sat",  32'(bs.Sum),  32'hFF);
    chk("r33_cout_sat", 32'(bs.Cout), 32'd1);
    finish_run();

    // A zero-length run gives an empty result and never raises In_Ready.
    start_run(4'd0);
    chk("r34_valid", 32'(bw.Out_Valid), 32'd1);
    chk("r34_res",   32'({bw.Sum, bw.Cout, bw.Count, bw.In_Ready}), 32'd0);
    finish_run();

    // Gaps between operands, then a stalled result while Start is pulsed.
    start_run(4'd2);
    send_op(8'h07);
    in_valid = 1'b0; repeat (3) tick();
    send_op(8'h09);
    start = 1'b1; len = 4'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("r35_hold_valid", 32'(bw.Out_Valid), 32'd1);
      chk("r35_hold_sum",   32'(bw.Sum),       32'h10);
    end
    out_ready = 1'b1;   // Start stays high in the handshake cycle
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("r35_idle", 32'({bw.Out_Valid, bw.Busy}), 32'd0);
    tick();
    chk("r35_no_run", 32'({bw.Busy, bw.In_Ready}), 32'd0);

    // Reset in the middle of a run discards it.
    start_run(4'd4);
    send_op(8'h33); send_op(8'h44);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("r36_rst", 32'({bw.Sum, bw.Cout, bw.Count, bw.In_Ready, bw.Out_Valid, bw.Busy}), 32'd0);
    start_run(4'd1);
    send_op(8'h05);
    chk("r36_sum",   32'(bw.Sum),   32'h05);
    chk("r36_count", 32'(bw.Count), 32'd1);
    finish_run();

    // Full-length run. An extra operand after DONE is not taken.
    start_run(4'd15);
    for (int i = 0; i < 15; i++) send_op(8'h11);
    chk("r37_sum",  32'(bw.Sum),  32'hFF);
    chk("r37_cout", 32'(bw.Cout), 32'd0);
    in_valid = 1'b1; in_data = 8'h22;
    tick();
    chk("r37_no_accept", 32'({bw.In_Ready, bw.Count}), 32'({1'b0, 4'd15}));
    in_valid = 1'b0;
    finish_run();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 3) == 0);
      len       = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(200, 255));
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
